// File: rtl/byte_word_loader.sv
// rtl/byte_word_loader.sv - packs a byte stream into words and drives a one-cycle load strobe
// Optional build macro BIG_ENDIAN_EN: the first byte of each word lands in the most significant lane.
module byte_word_loader #(
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 4,
    localparam int WORD_W        = BYTE_W * BYTES_PER_WORD,
    localparam int CNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1
) (
    input  logic              i_clk,
    input  logic              i_clear_n,
    input  logic [BYTE_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_abort,
    output logic [WORD_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_load,
    output logic [CNT_W-1:0]  o_byte_cnt
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD - 1);

    state_t            r_state;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_out_data;

    logic              w_in_ready;
    logic              w_take;
    logic [CNT_W-1:0]  w_lane;
    logic [WORD_W-1:0] w_shift_next;

    // While a word is waiting, a new byte may only enter in the cycle the word leaves.
    assign w_in_ready = (r_state == ST_FILL) || i_out_ready;
    assign w_take     = i_in_valid && w_in_ready && !i_abort;

`ifdef BIG_ENDIAN_EN
    assign w_lane = LAST_CNT - r_byte_cnt;
`else
    assign w_lane = r_byte_cnt;
`endif

    always_comb begin
        w_shift_next = r_shift;
        w_shift_next[int'(w_lane) * BYTE_W +: BYTE_W] = i_in_data;
    end

    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_state     <= ST_FILL;
            r_out_valid <= 1'b0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_out_data  <= '0;
        end else if (w_take) begin
            r_shift <= w_shift_next;
            if (r_byte_cnt == LAST_CNT) begin
                r_out_data  <= w_shift_next;
                r_byte_cnt  <= '0;
                r_state     <= ST_FULL;
                r_out_valid <= 1'b1;
            end else begin
                r_byte_cnt  <= r_byte_cnt + CNT_W'(1);
                r_state     <= ST_FILL;
                r_out_valid <= 1'b0;
            end
        end else begin
            // In FULL the count is already zero, so abort only matters for a partial word.
            if (i_abort && r_state == ST_FILL) begin
                r_byte_cnt <= '0;
            end
            if (r_state == ST_FULL && i_out_ready) begin
                r_state     <= ST_FILL;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_byte_cnt  = r_byte_cnt;
    assign o_load      = r_out_valid && i_out_ready;

endmodule

// File: tb/tb_byte_word_loader.sv
// tb/tb_byte_word_loader.sv - directed self-checking bench for byte_word_loader
module tb_byte_word_loader;

    logic        clk;
    logic        clear_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        abort;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        load;
    logic [1:0]  byte_cnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BIG_ENDIAN_EN
    localparam logic [31:0] W_1234 = 32'h11223344;
    localparam logic [31:0] W_0104 = 32'h01020304;
    localparam logic [31:0] W_0508 = 32'h05060708;
`else
    localparam logic [31:0] W_1234 = 32'h44332211;
    localparam logic [31:0] W_0104 = 32'h04030201;
    localparam logic [31:0] W_0508 = 32'h08070605;
`endif

    byte_word_loader #(.BYTE_W(8), .BYTES_PER_WORD(4)) dut (
        .i_clk       (clk),
        .i_clear_n   (clear_n),
        .i_in_data   (in_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_abort     (abort),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_load      (load),
        .o_byte_cnt  (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_byte_cnt",  {30'd0, byte_cnt},  32'd0);
        check("rst_out_data",  out_data,           32'd0);
        check("rst_load",      {31'd0, load},      32'd0);
        @(negedge clk);
        clear_n = 1'b1;
        tick();
    endtask

    initial begin
        clear_n   = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #12;
        do_reset();

        // Test 1: basic word with downstream always ready
        out_ready = 1'b1;
        send_byte(8'h11);
        check("t1_cnt1", {30'd0, byte_cnt}, 32'd1);
        send_byte(8'h22);
        send_byte(8'h33);
        check("t1_no_valid_early", {31'd0, out_valid}, 32'd0);
        send_byte(8'h44);
        in_valid = 1'b0;
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_data",  out_data, W_1234);
        check("t1_load",  {31'd0, load}, 32'd1);
        tick();
        check("t1_valid_drop", {31'd0, out_valid}, 32'd0);
        check("t1_load_drop",  {31'd0, load}, 32'd0);

        // Test 2: stalled downstream, offered byte must not disturb held word
        out_ready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        in_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            check("t2_valid_held", {31'd0, out_valid}, 32'd1);
            check("t2_in_ready",   {31'd0, in_ready},  32'd0);
            check("t2_data_held",  out_data, W_1234);
            check("t2_no_load",    {31'd0, load}, 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t2_load_release", {31'd0, load}, 32'd1);
        tick();
        check("t2_load_once", {31'd0, load}, 32'd0);
        check("t2_valid_gone", {31'd0, out_valid}, 32'd0);
        check("t2_cnt_zero", {30'd0, byte_cnt}, 32'd0);

        // Test 3: back-to-back stream, no bubble on in_ready
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            #1;
            check("t3_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            if (i == 4) begin
                check("t3_w0_valid", {31'd0, out_valid}, 32'd1);
                check("t3_w0_data",  out_data, W_0104);
                check("t3_w0_load",  {31'd0, load}, 32'd1);
            end
            if (i == 5) begin
                check("t3_pass_cnt", {30'd0, byte_cnt}, 32'd1);
                check("t3_pass_state", {31'd0, out_valid}, 32'd0);
            end
            if (i == 8) begin
                check("t3_w1_valid", {31'd0, out_valid}, 32'd1);
                check("t3_w1_data",  out_data, W_0508);
            end
        end
        in_valid = 1'b0;
        tick();
        check("t3_idle", {31'd0, out_valid}, 32'd0);

        // Test 4: abort mid-word drops partial lanes and the same-cycle byte
        out_ready = 1'b0;
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("t4_cnt2", {30'd0, byte_cnt}, 32'd2);
        abort   = 1'b1;
        in_data = 8'hCC;
        #1;
        check("t4_ready_abort", {31'd0, in_ready}, 32'd1);
        tick();
        abort = 1'b0;
        check("t4_cnt_abort", {30'd0, byte_cnt}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        in_valid = 1'b0;
        check("t4_valid", {31'd0, out_valid}, 32'd1);
        check("t4_data",  out_data, W_0104);
        abort = 1'b1;
        tick();
        check("t4_full_abort_keep", {31'd0, out_valid}, 32'd1);
        check("t4_full_abort_data", out_data, W_0104);
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        #1;
        check("t4_full_abort_load", {31'd0, load}, 32'd1);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("t4_drop_cnt",   {30'd0, byte_cnt}, 32'd0);
        check("t4_drop_valid", {31'd0, out_valid}, 32'd0);

        // Test 5: async reset mid-word and while a word is held
        send_byte(8'h10);
        send_byte(8'h20);
        in_valid = 1'b0;
        check("t5_cnt2", {30'd0, byte_cnt}, 32'd2);
        do_reset();
        out_ready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        in_valid = 1'b0;
        check("t5_full", {31'd0, out_valid}, 32'd1);
        clear_n   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t5_no_load", {31'd0, load}, 32'd0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
